// File: rtl/maxnet_feeder.sv
// maxnet_feeder: loads eps/a1..a4 operands, pulses start to the core,
// waits for finish under a watchdog and returns the result over valid/ready.
module maxnet_feeder #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] eps,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic              start,
    input  logic              finish,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [2:0]       idx;
    logic [CNT_W-1:0] wd;
    logic             accept;
    logic             wd_last;
    logic             fin_hit;
    logic             to_hit;

    assign accept  = in_valid & in_ready;
    assign wd_last = (wd == CNT_W'(TIMEOUT_CYCLES - 1));
    // finish takes priority over an expiring watchdog in the same cycle
    assign fin_hit = (state == WAIT) & finish;
    assign to_hit  = (state == WAIT) & ~finish & wd_last;

    assign in_ready  = (state == LOAD) & ~rst;
    assign start     = (state == START);
    assign busy      = (state == START) | (state == WAIT);
    assign res_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: begin
                if (accept && idx == 3'd4) begin
                    state_nx = START;
                end
            end
            START: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (fin_hit || to_hit) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nx = LOAD;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 3'd0;
            eps <= '0;
            a1  <= '0;
            a2  <= '0;
            a3  <= '0;
            a4  <= '0;
        end else if (accept) begin
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            case (idx)
                3'd0:    eps <= in_data;
                3'd1:    a1  <= in_data;
                3'd2:    a2  <= in_data;
                3'd3:    a3  <= in_data;
                3'd4:    a4  <= in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd       <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (state == START) begin
            wd <= '0;
        end else if (fin_hit) begin
            res_data <= result;
            res_err  <= 1'b0;
        end else if (to_hit) begin
            res_data <= '0;
            res_err  <= 1'b1;
        end else if (state == WAIT) begin
            wd <= wd + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_maxnet_feeder.sv
// tb_maxnet_feeder: table-driven and randomized runs against a stub core,
// checking handshakes, start pulse, watchdog and reset behaviour.
module tb_maxnet_feeder;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] eps, a1, a2, a3, a4;
    logic        start;
    logic        finish;
    logic [31:0] result;
    logic [31:0] res_data;
    logic        res_err;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    always #5 clk = ~clk;

    maxnet_feeder #(
        .DATA_W(32),
        .TIMEOUT_CYCLES(T),
        .CNT_W($clog2(T))
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .eps(eps),
        .a1(a1),
        .a2(a2),
        .a3(a3),
        .a4(a4),
        .start(start),
        .finish(finish),
        .result(result),
        .res_data(res_data),
        .res_err(res_err),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .busy(busy)
    );

    typedef logic [4:0][31:0] w5_t;

    typedef struct {
        w5_t         w;
        int          gap;
        int          d;
        bit          fs;
        logic [31:0] r;
        logic [31:0] exp_d;
        bit          exp_e;
        int          hold;
        bit          extra;
    } vec_t;

    vec_t tbl[6];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic w5_t mk(input logic [31:0] e, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [31:0] x3,
                               input logic [31:0] x4);
        w5_t w;
        w[0] = e;
        w[1] = x1;
        w[2] = x2;
        w[3] = x3;
        w[4] = x4;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ops(input string nm, input w5_t w);
        chk({nm, "_eps"}, eps, w[0]);
        chk({nm, "_a1"}, a1, w[1]);
        chk({nm, "_a2"}, a2, w[2]);
        chk({nm, "_a3"}, a3, w[3]);
        chk({nm, "_a4"}, a4, w[4]);
    endtask

    // Returns positioned in the START cycle (just after the fifth accept).
    task automatic load5(input w5_t w, input int gapmax);
        int g;
        bit acc;
        int b;
        for (int i = 0; i < 5; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            in_valid = 1'b0;
            repeat (g) begin
                in_data = $urandom;
                tick();
                chk("gap_in_ready", in_ready, 1);
            end
            in_data  = w[i];
            in_valid = 1'b1;
            acc = 1'b0;
            b   = 0;
            while (!acc && b < 20) begin
                acc = in_ready;
                tick();
                b++;
            end
            if (!acc) chk("load_accept", acc, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_rest(input w5_t w, input int d, input bit fs,
                            input logic [31:0] r, input logic [31:0] exp_d,
                            input bit exp_e, input int hold, input bit extra);
        int lat;
        lat = exp_e ? T : d;
        chk("start_hi", start, 1);
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 0);
        chk_ops("start", w);
        if (extra) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
        end
        finish = fs;
        result = $urandom;
        tick();
        chk("start_one_cycle", start, 0);
        for (int c = 1; c <= lat; c++) begin
            chk("wait_busy", busy, 1);
            chk("wait_no_valid", res_valid, 0);
            chk("wait_in_ready", in_ready, 0);
            finish = (c == d);
            result = (c == d) ? r : $urandom;
            tick();
        end
        finish = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_d);
        chk("res_err", res_err, exp_e);
        chk("hold_busy", busy, 0);
        chk("hold_start", start, 0);
        for (int h = 0; h < hold; h++) begin
            result    = $urandom;
            finish    = 1'($urandom_range(1, 0));
            res_ready = 1'b0;
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, exp_d);
            chk("hold_err", res_err, exp_e);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_eps", eps, w[0]);
        end
        finish    = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("exit_valid", res_valid, 0);
        chk("exit_in_ready", in_ready, 1);
        chk_ops("exit", w);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ops"}, eps | a1 | a2 | a3 | a4, 0);
        chk({nm, "_res_data"}, res_data, 0);
        chk({nm, "_flags"}, {start, res_valid, res_err, busy}, 0);
    endtask

    initial begin
        w5_t         pw;
        w5_t         rw;
        int          d;
        logic [31:0] r;

        pw = mk(32'hBE4CCCCD, 32'h461C3FA7, 32'hC61C3FA7,
                32'h3FA66666, 32'hC61C3FA7);
        tbl[0] = '{pw, 0, 7, 1'b0, 32'h461C3FA7, 32'h461C3FA7, 1'b0, 5, 1'b0};
        tbl[1] = '{mk(32'hBE4CCCCD, 32'h461C3FA7, 32'hC61C3FA7,
                      32'h40000000, 32'hC61C3FA7),
                   0, 3, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1, 1'b0};
        tbl[2] = '{pw, 3, 16, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 2, 1'b1};
        tbl[3] = '{pw, 2, 1000, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 3, 1'b1};
        tbl[4] = '{pw, 1, 17, 1'b1, 32'h11111111, 32'h0, 1'b1, 0, 1'b0};
        tbl[5] = '{mk(32'h1, 32'h2, 32'h3, 32'h4, 32'h5),
                   0, 1, 1'b0, 32'h7F800000, 32'h7F800000, 1'b0, 0, 1'b0};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        finish    = 1'b0;
        result    = '0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk_zero("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            load5(tbl[i].w, tbl[i].gap);
            run_rest(tbl[i].w, tbl[i].d, tbl[i].fs, tbl[i].r,
                     tbl[i].exp_d, tbl[i].exp_e, tbl[i].hold, tbl[i].extra);
        end

        load5(pw, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", in_ready, 0);
        chk_zero("midrst");
        rst = 1'b0;
        #1;
        chk("midrst_rel_in_ready", in_ready, 1);
        finish = 1'b1;
        result = 32'hBAADF00D;
        repeat (3) begin
            tick();
            chk("stale_fin_valid", res_valid, 0);
            chk("stale_fin_busy", busy, 0);
            chk("stale_fin_in_ready", in_ready, 1);
        end
        finish = 1'b0;
        chk_zero("stale_fin");
        load5(tbl[1].w, 1);
        run_rest(tbl[1].w, 5, 1'b0, 32'h42280000, 32'h42280000, 1'b0, 1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < 5; j++) rw[j] = $urandom;
            d = int'($urandom_range(T + 8, 1));
            r = $urandom;
            load5(rw, 3);
            run_rest(rw, d, 1'($urandom_range(1, 0)), r,
                     (d <= T) ? r : 32'h0, (d > T),
                     int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
